inv_sub_bytes_iter: RTL

INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

---
 rtl/inv_sub_bytes_iter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: a 128-bit state word is substituted LANES bytes per cycle,
// with a valid/ready handshake on both sides.
module inv_sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int PASSES = 16 / LANES;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int LW = 8 * LANES;
   localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_pass, w_pass_nxt;
   logic [127:0]  r_data, w_data_nxt;
   logic [127:0]  w_data_sub;
   logic [LW-1:0] w_lane_in, w_lane_sub;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse affine transform, then x^254 (the GF(2^8) inverse, which maps 0 to 0).
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] b;
      logic [7:0] sq;
      logic [7:0] acc;
      b   = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      sq  = b;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   generate
      if (PASSES == 1) begin : g_single
         assign w_lane_in  = r_data;
         assign w_data_sub = w_lane_sub;
      end else begin : g_multi
         logic [LW-1:0] w_chunks [PASSES];
         for (genvar p = 0; p < PASSES; p++) begin : g_chunk
            assign w_chunks[p] = r_data[p*LW +: LW];
            assign w_data_sub[p*LW +: LW] = (r_pass == PW'(p)) ? w_lane_sub : r_data[p*LW +: LW];
         end
         assign w_lane_in = w_chunks[r_pass];
      end
   endgenerate

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_lane_sub[8*l +: 8] = inv_sbox(w_lane_in[8*l +: 8]);
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_pass_nxt  = r_pass;
      w_data_nxt  = r_data;
      if (clear) begin
         w_state_nxt = IDLE;
         w_pass_nxt  = '0;
         w_data_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  w_state_nxt = BUSY;
                  w_pass_nxt  = '0;
                  w_data_nxt  = in_data;
               end
            end
            BUSY: begin
               w_data_nxt = w_data_sub;
               if (r_pass == LAST_PASS) begin
                  w_state_nxt = DONE;
                  w_pass_nxt  = '0;
               end else begin
                  w_pass_nxt = r_pass + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) w_state_nxt = IDLE;
            end
            default: begin
               w_state_nxt = IDLE;
               w_pass_nxt  = '0;
               w_data_nxt  = '0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pass  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pass  <= w_pass_nxt;
         r_data  <= w_data_nxt;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == BUSY);
   assign out_data  = r_data;

endmodule
